// File: rtl/pipe_credit_output_fifo.sv
// Purpose: credit-tracked output FIFO behind a valid-only pipeline; presents results on valid/ready.
// Latency: one cycle from push to out_vld (no empty-FIFO bypass); credit freed by a pop is visible next cycle.
// Backpressure: the pipeline cannot be stalled, so out_rdy is absorbed by withholding issue credits upstream.
// Ports: clk/rst_n (async active-low); issue_vld/issue_allowed launch handshake; in_vld/in_data pipeline
//        output; out_vld/out_data/out_rdy consumer handshake; occupancy, inflight counters; err_overflow sticky.
module pipe_credit_output_fifo #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_vld,
  output logic                       issue_allowed,
  input  logic                       in_vld,
  input  logic [width-1:0]           in_data,
  output logic                       out_vld,
  output logic [width-1:0]           out_data,
  input  logic                       out_rdy,
  output logic [$clog2(depth+1)-1:0] occupancy,
  output logic [$clog2(depth+1)-1:0] inflight,
  output logic                       err_overflow
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(depth);
  localparam logic [CW-1:0] DEPTH_C   = CW'(depth);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic          full;
  logic          pop;
  logic          push;
  logic          issue;
  logic          push_err;
  logic          arrive_err;
  logic [CW:0]   credit_used;
  logic [CW-1:0] occupancy_nxt;
  logic [CW-1:0] inflight_nxt;

  // Credits come from registered counters only, so the consumer's out_rdy never
  // reaches issue_allowed combinationally.
  assign credit_used   = {1'b0, occupancy} + {1'b0, inflight};
  assign issue_allowed = (credit_used < DEPTH_EXT);
  assign issue         = issue_vld && issue_allowed;

  assign full    = (occupancy == DEPTH_C);
  assign out_vld = (occupancy != '0);
  assign pop     = out_vld && out_rdy;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign push    = in_vld && (!full || pop);

  assign push_err   = in_vld && full && !pop;
  assign arrive_err = in_vld && (inflight == '0);

  assign out_data = mem[rd_ptr];

  always_comb begin
    occupancy_nxt = occupancy;
    if (push && !pop) begin
      occupancy_nxt = occupancy + 1'b1;
    end else if (pop && !push) begin
      occupancy_nxt = occupancy - 1'b1;
    end
  end

  // A return with nothing outstanding saturates at zero instead of wrapping.
  always_comb begin
    inflight_nxt = inflight;
    if (issue && !in_vld) begin
      inflight_nxt = inflight + 1'b1;
    end else if (!issue && in_vld && (inflight != '0)) begin
      inflight_nxt = inflight - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      inflight     <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occupancy <= occupancy_nxt;
      inflight  <= inflight_nxt;
      if (push_err || arrive_err) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; out_vld qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_credit_output_fifo.sv
// Purpose: randomized and directed bench for pipe_credit_output_fifo against a queue-based model.
// Latency: model state is updated one clock after the inputs it consumes, matching registered outputs.
// Backpressure: a 3-stage valid-only pipe model launches only when the model grants a credit.
module tb_pipe_credit_output_fifo;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_vld = 1'b0;
  logic          in_vld = 1'b0;
  logic          out_rdy = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          issue_allowed;
  logic          out_vld;
  logic          err_overflow;
  logic [W-1:0]  out_data;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, outstanding launches as an integer.
  logic [W-1:0] mq[$];
  int           m_inf = 0;
  bit           m_err = 1'b0;

  // Bench-side 3-cycle valid-only pipeline.
  bit           pv[3];
  logic [W-1:0] pd[3];
  logic [W-1:0] seq = '0;

  always #5 clk = ~clk;

  pipe_credit_output_fifo #(.width(W), .depth(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_vld    (issue_vld),
    .issue_allowed(issue_allowed),
    .in_vld       (in_vld),
    .in_data      (in_data),
    .out_vld      (out_vld),
    .out_data     (out_data),
    .out_rdy      (out_rdy),
    .occupancy    (occupancy),
    .inflight     (inflight),
    .err_overflow (err_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_allowed();
    return (mq.size() + m_inf) < D;
  endfunction

  task automatic check_state();
    check_eq("occupancy", 32'(occupancy), 32'(mq.size()));
    check_eq("inflight", 32'(inflight), 32'(m_inf));
    check_eq("issue_allowed", 32'(issue_allowed), 32'(model_allowed()));
    check_eq("out_vld", 32'(out_vld), 32'(mq.size() != 0));
    check_eq("err_overflow", 32'(err_overflow), 32'(m_err));
    if (mq.size() != 0) check_eq("out_data", 32'(out_data), 32'(mq[0]));
  endtask

  // Check current outputs, advance one clock, then commit the model's next state.
  task automatic step();
    logic [W-1:0] q2[$];
    int inf2;
    bit err2, full, pop, iss;
    check_state();
    q2   = mq;
    err2 = m_err;
    full = (mq.size() == D);
    pop  = (mq.size() != 0) && out_rdy;
    iss  = issue_vld && model_allowed();
    if (pop) void'(q2.pop_front());
    if (in_vld) begin
      if (full && !pop) err2 = 1'b1;
      else q2.push_back(in_data);
      if (m_inf == 0) err2 = 1'b1;
    end
    inf2 = m_inf + int'(iss) - int'(in_vld);
    if (inf2 < 0) inf2 = 0;
    @(posedge clk);
    #1;
    mq    = q2;
    m_inf = inf2;
    m_err = err2;
  endtask

  task automatic pipe_cycle(input bit req, input bit rdy);
    bit acc;
    acc       = req && model_allowed();
    issue_vld = req;
    out_rdy   = rdy;
    in_vld    = pv[2];
    in_data   = pd[2];
    step();
    pv[2] = pv[1]; pd[2] = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0];
    pv[0] = acc;   pd[0] = seq;
    if (acc) seq++;
    issue_vld = 1'b0;
    in_vld    = 1'b0;
  endtask

  // Assert reset between edges and check the outputs before any clock arrives.
  task automatic do_reset();
    #3;
    rst_n     = 1'b0;
    issue_vld = 1'b0;
    in_vld    = 1'b0;
    out_rdy   = 1'b0;
    #1;
    mq.delete();
    m_inf = 0;
    m_err = 1'b0;
    pv    = '{default: 1'b0};
    check_eq("rst_out_vld", 32'(out_vld), 32'd0);
    check_eq("rst_issue_allowed", 32'(issue_allowed), 32'd1);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    check_eq("rst_err", 32'(err_overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Credit exhaustion with the consumer stalled.
    for (int i = 0; i < 10; i++) begin
      issue_vld = 1'b1;
      out_rdy   = 1'b0;
      if (i == 7) check_eq("credit_last", 32'(issue_allowed), 32'd1);
      if (i == 8) check_eq("credit_drop", 32'(issue_allowed), 32'd0);
      step();
    end
    issue_vld = 1'b0;
    check_eq("inflight_full", 32'(inflight), 32'd8);
    for (int i = 0; i < 8; i++) begin
      in_vld  = 1'b1;
      in_data = W'(8'h10 + i);
      step();
    end
    in_vld = 1'b0;
    check_eq("fill_occ", 32'(occupancy), 32'd8);
    check_eq("fill_inflight", 32'(inflight), 32'd0);
    check_eq("fill_err", 32'(err_overflow), 32'd0);

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      out_rdy = 1'b1;
      check_eq("drain_vld", 32'(out_vld), 32'd1);
      check_eq("drain_data", 32'(out_data), 32'(8'h10 + i));
      step();
      if (i == 0) check_eq("allowed_after_pop", 32'(issue_allowed), 32'd1);
    end
    out_rdy = 1'b0;
    check_eq("drain_empty", 32'(out_vld), 32'd0);

    // Steady state through the 3-cycle pipe, wrapping the pointers several times.
    for (int i = 0; i < 40; i++) begin
      pipe_cycle(1'b1, 1'b1);
      if (i >= 4) begin
        check_eq("steady_vld", 32'(out_vld), 32'd1);
        check_eq("steady_occ_le1", 32'(occupancy <= 1), 32'd1);
      end
    end
    for (int i = 0; i < 6; i++) pipe_cycle(1'b0, 1'b1);
    check_eq("steady_flushed", 32'(out_vld), 32'd0);
    check_eq("steady_err", 32'(err_overflow), 32'd0);

    // Random launches and consumer stalls.
    for (int i = 0; i < 300; i++) begin
      pipe_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3);
      check_eq("invariant", 32'((occupancy + inflight) <= D), 32'd1);
    end
    for (int i = 0; i < 20; i++) pipe_cycle(1'b0, 1'b1);
    check_eq("random_drained", 32'(occupancy), 32'd0);
    check_eq("random_err", 32'(err_overflow), 32'd0);

    // Unsolicited return, then overfill with the consumer stalled.
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 8'hE0;
    step();
    in_vld = 1'b0;
    check_eq("viol_err", 32'(err_overflow), 32'd1);
    check_eq("viol_inflight", 32'(inflight), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      in_vld  = 1'b1;
      in_data = W'(8'hE0 + i);
      step();
    end
    in_vld = 1'b0;
    check_eq("overfill_occ", 32'(occupancy), 32'd8);
    check_eq("overfill_head", 32'(out_data), 32'hE0);
    // Push and pop together on a full FIFO.
    in_vld  = 1'b1;
    in_data = 8'hF0;
    out_rdy = 1'b1;
    step();
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    check_eq("passthru_occ", 32'(occupancy), 32'd8);
    step();
    check_eq("err_sticky", 32'(err_overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      out_rdy = 1'b1;
      step();
    end
    out_rdy = 1'b0;
    check_eq("viol_drained", 32'(out_vld), 32'd0);
    check_eq("err_still_sticky", 32'(err_overflow), 32'd1);

    // Reset in the middle of traffic.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      issue_vld = 1'b1;
      step();
    end
    issue_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_vld  = 1'b1;
      in_data = W'(8'h30 + i);
      step();
    end
    in_vld = 1'b0;
    check_eq("pre_rst_occ", 32'(occupancy), 32'd5);
    check_eq("pre_rst_inflight", 32'(inflight), 32'd2);
    do_reset();
    issue_vld = 1'b1;
    step();
    issue_vld = 1'b0;
    step();
    in_vld  = 1'b1;
    in_data = 8'hAB;
    step();
    in_vld = 1'b0;
    check_eq("post_rst_vld", 32'(out_vld), 32'd1);
    check_eq("post_rst_data", 32'(out_data), 32'hAB);
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_credit_output_fifo.md
Name: pipe_credit_output_fifo

Overview:
- Sits directly downstream of a valid-only pipeline, such as a valid-qualified shift register or a sqrt/formula pipe, which has no backpressure.
- Buffers the pipeline's output transfers in a FIFO and presents them to a consumer with a valid/ready handshake.
- Tracks in-flight transfers and grants credits to the issuing stage. The pipeline therefore never delivers a result into a full FIFO.

Parameters:
- width, 8: data width of every transfer.
- depth, 8: FIFO entries and total credit pool. Must be >= 2 and a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- issue_vld  input  1  upstream requests to launch one transfer into the pipeline this cycle.
- issue_allowed  output  1  a credit is available; a launch is accepted when issue_vld && issue_allowed.
- in_vld  input  1  pipeline output transfer is valid.
- in_data  input  width  pipeline output data.
- out_vld  output  1  FIFO head is valid.
- out_data  output  width  FIFO head data.
- out_rdy  input  1  consumer accepts the head; a pop occurs when out_vld && out_rdy.
- occupancy  output  $clog2(depth+1)  entries currently stored.
- inflight  output  $clog2(depth+1)  accepted launches not yet returned on in_vld.
- err_overflow  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - occupancy=0, inflight=0, err_overflow=0.
  - Read and write pointers = 0, so out_vld=0 and issue_allowed=1.
  - out_data is don't-care while out_vld=0. The bench must not check it then.
  - Storage array is not reset.
- Credits:
  - issue_allowed = (occupancy + inflight) < depth. It is combinational from registered counters only.
  - It does not depend on same-cycle out_rdy. A pop frees a credit in the following cycle.
- Launch: issue = issue_vld && issue_allowed. issue_vld while issue_allowed=0 is ignored (no state change, no error).
- inflight update, next = inflight + issue - arrive, where arrive = in_vld:
  - Simultaneous issue and arrive: inflight unchanged.
  - arrive with inflight=0: push still performed if not full; inflight stays 0 (saturate, no underflow); err_overflow set.
- Push:
  - in_vld writes in_data at wr_ptr and increments wr_ptr, with wrap-around modulo depth.
  - If occupancy==depth and no pop in the same cycle: data dropped, pointers unchanged, err_overflow set.
  - If occupancy==depth and pop in the same cycle: push accepted (pass-through on a full FIFO).
- Pop: out_vld = (occupancy != 0). On out_vld && out_rdy, rd_ptr increments with wrap.
- occupancy update, next = occupancy + push - pop:
  - Simultaneous push and pop: unchanged.
  - On an empty FIFO, a push cannot be popped in the same cycle; no combinational bypass.
- Latency:
  - A transfer pushed at edge t appears on out_vld/out_data after edge t (visible in cycle t+1).
  - out_data = mem[rd_ptr], read combinationally from registered storage.
- Ordering: strict FIFO; data is never reordered or duplicated.
- err_overflow: sticky until rst_n is asserted.
- Reset mid-operation: all stored and in-flight transfers are discarded immediately. The next rising edge after deassertion operates from the reset state.
- Invariant, when the protocol is obeyed: occupancy + inflight <= depth.

Test Plan:
- Reset check:
  - Stimulus: assert rst_n=0 asynchronously between edges.
  - Response: out_vld=0, issue_allowed=1, occupancy=0, inflight=0, err_overflow=0 without waiting for a clock.
- Credit exhaustion, depth=8, out_rdy=0:
  - Stimulus: issue_vld=1 for 10 cycles, then return 8 results on in_vld with data 0x10..0x17.
  - Response: issue_allowed drops after 8 accepted launches; inflight=8 then goes 8→0; occupancy goes 0→8; err_overflow stays 0.
- Drain ordering:
  - Stimulus: continuing from the previous case, out_rdy=1.
  - Response: out_data sequence 0x10..0x17 on 8 consecutive cycles, then out_vld=0. issue_allowed=1 the cycle after the first pop.
- Steady state with a 3-cycle pipe model:
  - Stimulus: continuous issue, out_rdy=1.
  - Response: one out_vld per cycle after fill; occupancy<=1; no errors; data matches issue order across pointer wrap (>16 transfers).
- Protocol violation:
  - Stimulus: in_vld=1 with inflight=0.
  - Response: err_overflow=1, inflight stays 0, and it remains set until reset.
  - Stimulus: also push into a full FIFO with out_rdy=0.
  - Response: data dropped, occupancy stays 8.
- Reset mid-operation:
  - Stimulus: occupancy=5, inflight=2, pulse rst_n low.
  - Response: all counters 0, out_vld=0 immediately. A subsequent transfer 0xAB emerges as the first out_data.
